// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI-lite slave backed by a 32-bit word array with byte strobes,
// a fixed access latency and SLVERR responses outside the mapped address window.
module axi_lite_sram #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_W     = 32'(MEM_DEPTH);
  localparam logic [3:0]  LAT_W       = 4'(LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Byte offsets below BASE_ADDR wrap to huge values, so the lower-bound test is explicit.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 5'd2) < DEPTH_W);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 5'd2);
  endfunction

  logic [31:0] mem [MEM_DEPTH];

  r_state_t         r_state_r;
  logic [3:0]       r_cnt_r;
  logic [IDX_W-1:0] ar_idx_r;
  logic             ar_ok_r;
  logic             arready_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;

  w_state_t         w_state_r;
  logic [3:0]       w_cnt_r;
  logic             aw_held_r;
  logic             w_held_r;
  logic [IDX_W-1:0] aw_idx_r;
  logic             aw_ok_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic             awready_r;
  logic             wready_r;
  logic             bvalid_r;
  logic [1:0]       bresp_r;

  logic             aw_fire_s;
  logic             w_fire_s;
  logic             commit_s;

  assign aw_fire_s = awvalid && awready_r;
  assign w_fire_s  = wvalid && wready_r;
  assign commit_s  = (w_state_r == W_WAIT) && (w_cnt_r == 4'd0) && aw_ok_r;

  // Read channel: accept address, count down latency, present the captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      r_cnt_r   <= 4'd0;
      ar_idx_r  <= '0;
      ar_ok_r   <= 1'b0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= RESP_OKAY;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (arvalid && arready_r) begin
            ar_idx_r  <= addr_index(araddr);
            ar_ok_r   <= addr_in_range(araddr);
            r_cnt_r   <= LAT_W;
            arready_r <= 1'b0;
            r_state_r <= R_WAIT;
          end
        end
        R_WAIT: begin
          // A zero count is the capture cycle; the data is valid from the next edge.
          if (r_cnt_r == 4'd0) begin
            rdata_r   <= ar_ok_r ? mem[ar_idx_r] : 32'h0000_0000;
            rresp_r   <= ar_ok_r ? RESP_OKAY : RESP_SLVERR;
            rvalid_r  <= 1'b1;
            r_state_r <= R_RESP;
          end else begin
            r_cnt_r <= r_cnt_r - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write channel: collect AW and W in any order, wait out latency, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      w_cnt_r   <= 4'd0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_idx_r  <= '0;
      aw_ok_r   <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_fire_s) begin
            aw_idx_r  <= addr_index(awaddr);
            aw_ok_r   <= addr_in_range(awaddr);
            aw_held_r <= 1'b1;
            awready_r <= 1'b0;
          end
          if (w_fire_s) begin
            wdata_r  <= wdata;
            wstrb_r  <= wstrb;
            w_held_r <= 1'b1;
            wready_r <= 1'b0;
          end
          if ((aw_held_r || aw_fire_s) && (w_held_r || w_fire_s)) begin
            w_cnt_r   <= LAT_W;
            w_state_r <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt_r == 4'd0) begin
            bresp_r   <= aw_ok_r ? RESP_OKAY : RESP_SLVERR;
            bvalid_r  <= 1'b1;
            w_state_r <= W_RESP;
          end else begin
            w_cnt_r <= w_cnt_r - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_r  <= 1'b0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          aw_held_r <= 1'b0;
          w_held_r  <= 1'b0;
          awready_r <= 1'b1;
          wready_r  <= 1'b1;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane commit on the response edge; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      if (wstrb_r[0]) mem[aw_idx_r][7:0]   <= wdata_r[7:0];
      if (wstrb_r[1]) mem[aw_idx_r][15:8]  <= wdata_r[15:8];
      if (wstrb_r[2]) mem[aw_idx_r][23:16] <= wdata_r[23:16];
      if (wstrb_r[3]) mem[aw_idx_r][31:24] <= wdata_r[31:24];
    end
  end

  assign arready = arready_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rvalid  = rvalid_r;
  assign awready = awready_r;
  assign wready  = wready_r;
  assign bresp   = bresp_r;
  assign bvalid  = bvalid_r;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: instance 0 is LATENCY=0/depth 1024, instance 1 is
// LATENCY=3/depth 100; table-driven transfers plus hand-written corner sequences.
module tb_axi_lite_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][31:0] araddr, rdata, awaddr, wdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0][1:0]  rresp, bresp;
  logic [1:0]       arvalid, arready, rvalid, rready;
  logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_sram #(
      .MEM_DEPTH ((g == 0) ? 1024 : 100),
      .BASE_ADDR (32'h8000_0000),
      .LATENCY   ((g == 0) ? 0 : 3)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr[g]),
      .arvalid (arvalid[g]),
      .arready (arready[g]),
      .rdata   (rdata[g]),
      .rresp   (rresp[g]),
      .rvalid  (rvalid[g]),
      .rready  (rready[g]),
      .awaddr  (awaddr[g]),
      .awvalid (awvalid[g]),
      .awready (awready[g]),
      .wdata   (wdata[g]),
      .wstrb   (wstrb[g]),
      .wvalid  (wvalid[g]),
      .wready  (wready[g]),
      .bresp   (bresp[g]),
      .bvalid  (bvalid[g]),
      .bready  (bready[g])
    );
  end

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [1:0] resp, input int lat, input string name);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = addr; v.data = data;
    v.strb = strb; v.resp = resp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic axi_read(input int d, input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit hs;
    int n;
    araddr[d] = addr; arvalid[d] = 1'b1; rready[d] = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      hs = arready[d];
      tick();
      n++;
    end
    arvalid[d] = 1'b0;
    lat = 0;
    while (!rvalid[d] && lat < 50) begin
      tick();
      lat++;
    end
    data = rdata[d];
    resp = rresp[d];
    tick();
    rready[d] = 1'b0;
  endtask

  task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    awaddr[d] = addr; awvalid[d] = 1'b1;
    wdata[d] = data; wstrb[d] = strb; wvalid[d] = 1'b1; bready[d] = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid[d] && awready[d];
      w_hs  = wvalid[d] && wready[d];
      tick();
      n++;
      if (aw_hs) begin aw_done = 1'b1; awvalid[d] = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid[d]  = 1'b0; end
    end
    lat = 0;
    while (!bvalid[d] && lat < 50) begin
      tick();
      lat++;
    end
    resp = bresp[d];
    tick();
    bready[d] = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          lt;
  bit          seen;
  bit          stable;

  initial begin
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;

    // Reset asserted between clock edges must act immediately.
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset ready d%0d", d), 32'({arready[d], awready[d], wready[d]}), 32'h7);
      chk($sformatf("reset valid d%0d", d), 32'({rvalid[d], bvalid[d]}), 32'h0);
      chk($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
      chk($sformatf("reset resp d%0d", d), 32'({rresp[d], bresp[d]}), 32'h0);
    end
    tick(); tick();
    rst = 1'b0;
    tick();

    add(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1, "l0_wr_deadbeef");
    add(0, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00, 1, "l0_rd_deadbeef");
    add(0, 1'b0, 32'h8000_0013, 32'hDEAD_BEEF, 4'h0, 2'b00, 1, "l0_rd_unaligned");
    add(0, 1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 2'b00, 1, "l0_wr_first");
    add(0, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 1, "l0_wr_last");
    add(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 2'b10, 1, "l0_wr_below");
    add(0, 1'b1, 32'h8000_1000, 32'h8765_4321, 4'hF, 2'b10, 1, "l0_wr_above");
    add(0, 1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 2'b10, 1, "l0_rd_below");
    add(0, 1'b0, 32'h8000_1000, 32'h0000_0000, 4'h0, 2'b10, 1, "l0_rd_above");
    add(0, 1'b0, 32'h8000_0000, 32'h0102_0304, 4'h0, 2'b00, 1, "l0_rd_first_kept");
    add(0, 1'b0, 32'h8000_0FFC, 32'hCAFE_F00D, 4'h0, 2'b00, 1, "l0_rd_last_kept");
    add(1, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 4, "l3_wr_preload");
    add(1, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 4, "l3_wr_strb0101");
    add(1, 1'b0, 32'h8000_0020, 32'h11BB_33DD, 4'h0, 2'b00, 4, "l3_rd_merged");
    add(1, 1'b1, 32'h8000_0020, 32'h9999_9999, 4'h0, 2'b00, 4, "l3_wr_nostrb");
    add(1, 1'b0, 32'h8000_0020, 32'h11BB_33DD, 4'h0, 2'b00, 4, "l3_rd_nostrb");
    add(1, 1'b1, 32'h8000_0024, 32'h0000_0000, 4'hF, 2'b00, 4, "l3_wr_zero");
    add(1, 1'b1, 32'h8000_0024, 32'h1234_5678, 4'hA, 2'b00, 4, "l3_wr_strb1010");
    add(1, 1'b0, 32'h8000_0024, 32'h1200_5600, 4'h0, 2'b00, 4, "l3_rd_strb1010");
    add(1, 1'b1, 32'h8000_018C, 32'h0BAD_CAFE, 4'hF, 2'b00, 4, "l3_wr_last");
    add(1, 1'b1, 32'h8000_0190, 32'hFFFF_FFFF, 4'hF, 2'b10, 4, "l3_wr_above");
    add(1, 1'b0, 32'h8000_0190, 32'h0000_0000, 4'h0, 2'b10, 4, "l3_rd_above");
    add(1, 1'b0, 32'h8000_018C, 32'h0BAD_CAFE, 4'h0, 2'b00, 4, "l3_rd_last_kept");

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].d, vecs[i].addr, vecs[i].data, vecs[i].strb, rs, lt);
        chk({vecs[i].name, " bresp"}, 32'(rs), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].d, vecs[i].addr, rd, rs, lt);
        chk({vecs[i].name, " rdata"}, rd, vecs[i].data);
        chk({vecs[i].name, " rresp"}, 32'(rs), 32'(vecs[i].resp));
      end
      chk({vecs[i].name, " latency"}, 32'(lt), 32'(vecs[i].lat));
    end

    // W two cycles ahead of AW, then a stalled B channel.
    awaddr[1] = 32'h8000_0040; wdata[1] = 32'h5566_7788; wstrb[1] = 4'hF;
    wvalid[1] = 1'b1; bready[1] = 1'b0;
    chk("early_w wready", 32'(wready[1]), 32'h1);
    tick();
    wdata[1] = 32'h0000_0000;
    chk("early_w wready after hs", 32'(wready[1]), 32'h0);
    tick();
    chk("early_w still held", 32'({wready[1], awready[1], bvalid[1]}), 32'h2);
    awvalid[1] = 1'b1;
    tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    lt = 0;
    while (!bvalid[1] && lt < 50) begin tick(); lt++; end
    chk("early_w latency", 32'(lt), 32'h4);
    stable = 1'b1;
    wvalid[1] = 1'b1;
    repeat (5) begin
      tick();
      if (bvalid[1] !== 1'b1 || bresp[1] !== 2'b00 || wready[1] !== 1'b0 || awready[1] !== 1'b0)
        stable = 1'b0;
    end
    wvalid[1] = 1'b0;
    chk("early_w bvalid stable", 32'(stable), 32'h1);
    bready[1] = 1'b1;
    tick();
    bready[1] = 1'b0;
    chk("early_w release", 32'({bvalid[1], awready[1], wready[1]}), 32'h3);
    axi_read(1, 32'h8000_0040, rd, rs, lt);
    chk("early_w readback", rd, 32'h5566_7788);

    // Same-word read capture and write commit in one cycle, then stalled responses.
    araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1; rready[0] = 1'b0;
    awaddr[0] = 32'h8000_0000; awvalid[0] = 1'b1;
    wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF; wvalid[0] = 1'b1; bready[0] = 1'b0;
    tick();
    arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    tick();
    chk("collide rvalid/bvalid", 32'({rvalid[0], bvalid[0]}), 32'h3);
    chk("collide pre-write data", rdata[0], 32'h0102_0304);
    tick(); tick();
    chk("hold rdata", rdata[0], 32'h0102_0304);
    chk("hold ready low", 32'({rvalid[0], arready[0], awready[0]}), 32'h4);
    rready[0] = 1'b1;
    tick();
    rready[0] = 1'b0;
    chk("b2b arready after rready", 32'({arready[0], rvalid[0]}), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async reset bvalid", 32'(bvalid[0]), 32'h0);
    chk("async reset rdata", rdata[0], 32'h0);
    chk("async reset ready", 32'({arready[0], awready[0], wready[0]}), 32'h7);
    tick(); tick();
    rst = 1'b0;
    axi_read(0, 32'h8000_0000, rd, rs, lt);
    chk("collide post-write data", rd, 32'hFFFF_FFFF);

    // Reset in R_WAIT aborts the read.
    axi_write(1, 32'h8000_0050, 32'hA5A5_A5A5, 4'hF, rs, lt);
    araddr[1] = 32'h8000_0050; arvalid[1] = 1'b1; rready[1] = 1'b1;
    tick();
    arvalid[1] = 1'b0;
    tick();
    chk("rwait arready low", 32'(arready[1]), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rwait reset arready", 32'({arready[1], rvalid[1]}), 32'h2);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin tick(); if (rvalid[1]) seen = 1'b1; end
    chk("rwait no rvalid", 32'(seen), 32'h0);
    rready[1] = 1'b0;

    // Reset in W_WAIT with AW/W held must not commit.
    awaddr[1] = 32'h8000_0050; awvalid[1] = 1'b1;
    wdata[1] = 32'h0000_0000; wstrb[1] = 4'hF; wvalid[1] = 1'b1; bready[1] = 1'b1;
    tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    tick();
    chk("wwait held", 32'({awready[1], wready[1]}), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("wwait reset ready", 32'({awready[1], wready[1], bvalid[1]}), 32'h6);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin tick(); if (bvalid[1]) seen = 1'b1; end
    chk("wwait no bvalid", 32'(seen), 32'h0);
    bready[1] = 1'b0;
    axi_read(1, 32'h8000_0050, rd, rs, lt);
    chk("wwait word kept", rd, 32'hA5A5_A5A5);
    chk("wwait next read latency", 32'(lt), 32'h4);
    axi_write(1, 32'h8000_0050, 32'h00C0_FFEE, 4'hF, rs, lt);
    chk("post reset write latency", 32'(lt), 32'h4);
    axi_read(1, 32'h8000_0050, rd, rs, lt);
    chk("post reset readback", rd, 32'h00C0_FFEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

Parametrised AXI-lite slave memory with an internal word array, full read and write channels, byte strobes, configurable access latency and address-range decoding with error responses. It serves as the instruction or data memory behind a core's fetch or LSU AXI-lite master. Read and write paths run independent state machines and can be in flight at the same time.

## Interface
- `MEM_DEPTH`, 1024: number of 32-bit words; power of two not required.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 0: wait cycles between request acceptance and response; 0..15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `araddr`  in  `AXI_ADDR_BUS` (32)  read address.
- `arvalid` in 1; `arready` out 1.
- `rdata`  out  `AXI_DATA_BUS` (32); `rresp` out `AXI_RESP_BUS` (2); `rvalid` out 1; `rready` in 1.
- `awaddr`  in 32; `awvalid` in 1; `awready` out 1.
- `wdata`  in 32; `wstrb` in `AXI_WSTRB_BUS` (4); `wvalid` in 1; `wready` out 1.
- `bresp` out 2; `bvalid` out 1; `bready` in 1.

## Operation
- Decode: word index = (addr − BASE_ADDR) >> 2; addr[1:0] ignored. In range iff addr ≥ BASE_ADDR and index < MEM_DEPTH; otherwise resp = SLVERR (2'b10), else OKAY (2'b00).
- Read FSM R_IDLE → R_WAIT → R_RESP.
  - R_IDLE: arready=1; on arvalid&arready latch address, load counter with LATENCY; go to R_WAIT (LATENCY>0) or R_RESP (LATENCY=0).
  - R_WAIT: counter decrements each cycle; at 0 go to R_RESP.
  - On entry to R_RESP: capture rdata = mem[index] (0 if out of range) and rresp; rvalid=1.
  - R_RESP: hold rdata/rresp/rvalid stable until rready; then R_IDLE.
- Write FSM W_IDLE → W_WAIT → W_RESP.
  - W_IDLE: awready = !aw_held, wready = !w_held; AW and W accepted independently, either order or same cycle; each latched once.
  - When both held: load counter, go to W_WAIT (or directly commit when LATENCY=0).
  - Commit on entry to W_RESP: for each i with wstrb[i]=1 write mem[index][8i+7:8i]; out-of-range write dropped, bresp=SLVERR. bvalid=1 until bready; then clear held flags, W_IDLE.
- Same-word read capture and write commit in the same cycle: read returns pre-write data.
- Memory contents are not reset.

## Timing
- Reset (async assert, sync deassert by use): arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs to IDLE; held flags and counters cleared. Reset mid-transaction aborts it; a pending write is not committed.
- Read latency: AR handshake at edge N → rvalid high from edge N+1+LATENCY.
- Write latency: later of AW/W handshake at edge N → bvalid high from edge N+1+LATENCY.
- One outstanding read and one outstanding write maximum; arready=0 outside R_IDLE; awready/wready=0 once respective channel held or outside W_IDLE.
- Back-to-back: rready high in R_RESP at edge M → arready high from edge M; next AR accepted earliest edge M+1.
- No combinational path from any input to any output except none; all outputs registered or state-decoded.

## Test plan
- Reset: assert rst mid-cycle without clock → all outputs at reset values immediately; arready=awready=wready=1.
- LATENCY=0: write 32'hDEAD_BEEF, wstrb 4'hF to 0x8000_0010, then read same → bvalid one cycle after AW/W, bresp=OKAY; rdata=32'hDEAD_BEEF, rvalid one cycle after AR.
- Byte strobes, LATENCY=3: preload 32'h1122_3344, write 32'hAABB_CCDD wstrb 4'b0101 → readback 32'h11BB_33DD; rvalid exactly 4 cycles after AR handshake.
- W before AW by 2 cycles, then AW; bready held low 5 cycles → single commit, bvalid stable, wready low after W handshake, no second write.
- Out of range: read 0x7FFF_FFFC and 0x8000_0000+4*MEM_DEPTH → rresp=2'b10, rdata=0; write there → bresp=2'b10, memory unchanged.
- Reset during R_WAIT and during W_WAIT with AW/W held → no rvalid/bvalid after release, target word keeps old value, next transactions behave normally.
